// File: rtl/control_pkg.sv
// Shared types and sizing helpers for the charge-measurement and bisection control path.
package control_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCUM  = 2'd2
  } q_meas_state_t;

  localparam int DEFAULT_WIDTH = 10;

  function automatic int n_of(input int log2_samples);
    return 1 << log2_samples;
  endfunction

  function automatic int acc_w_of(input int width, input int log2_samples);
    return width + log2_samples;
  endfunction

  // Half an LSB of the averaged result; nothing to round when only one sample is taken.
  function automatic int round_of(input int log2_samples);
    int r;
    if (log2_samples == 0) begin
      r = 0;
    end else begin
      r = 1 << (log2_samples - 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/q_accumulator.sv
// Sample accumulator: clear, add-on-valid, sample count and final-sample flag.
module q_accumulator
  import control_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int LOG2_SAMPLES = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  input  logic                             add,
  input  logic [WIDTH-1:0]                 data,
  output logic [WIDTH+LOG2_SAMPLES-1:0]    sum,
  output logic                             last
);

  localparam int ACC_W = acc_w_of(WIDTH, LOG2_SAMPLES);
  localparam int CNT_W = LOG2_SAMPLES + 1;
  localparam int N     = n_of(LOG2_SAMPLES);

  logic [ACC_W-1:0] acc_q, acc_d, acc_base_s;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base_s;

  // A clear coinciding with an add loads the sample into an empty accumulator.
  assign acc_base_s = clear ? {ACC_W{1'b0}} : acc_q;
  assign cnt_base_s = clear ? {CNT_W{1'b0}} : cnt_q;
  assign sum        = acc_base_s + ACC_W'(data);
  assign last       = (cnt_base_s == CNT_W'(N - 1));

  // Next accumulator and sample count.
  always_comb begin
    acc_d = acc_base_s;
    cnt_d = cnt_base_s;
    if (add) begin
      acc_d = sum;
      cnt_d = cnt_base_s + CNT_W'(1);
    end else begin
      acc_d = acc_base_s;
      cnt_d = cnt_base_s;
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= {ACC_W{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/q_measure.sv
// Settled-average charge measurement: wait a settling interval after start, then
// average 2^LOG2_SAMPLES ADC samples and strobe the rounded result.
module q_measure
  import control_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int SETTLE_CYCLES = 16,
  parameter int LOG2_SAMPLES  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             adc_valid,
  input  logic [WIDTH-1:0] adc_data,
  output logic [WIDTH-1:0] measured_q,
  output logic             meas_valid,
  output logic             busy
);

  localparam int ACC_W = acc_w_of(WIDTH, LOG2_SAMPLES);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [ACC_W-1:0] ROUND = ACC_W'(round_of(LOG2_SAMPLES));

  q_meas_state_t    state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [WIDTH-1:0] measured_d;
  logic             meas_valid_q, meas_valid_d;
  logic             busy_q, busy_d;

  logic             settle_done_s;
  logic             sample_s;
  logic             acc_clear_s;
  logic             acc_add_s;
  logic             acc_last_s;
  logic [ACC_W-1:0] acc_sum_s;
  logic [ACC_W-1:0] rounded_s;

  // The last settle cycle already takes a sample, so the first one lands on edge SETTLE_CYCLES.
  assign settle_done_s = (state_q == SETTLE) && (settle_q == {SET_W{1'b0}});
  assign sample_s      = (state_q == ACCUM) || settle_done_s;
  assign acc_clear_s   = start || settle_done_s;
  assign acc_add_s     = !start && sample_s && adc_valid;
  assign rounded_s     = acc_sum_s + ROUND;

  q_accumulator #(
    .WIDTH        (WIDTH),
    .LOG2_SAMPLES (LOG2_SAMPLES)
  ) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (acc_clear_s),
    .add   (acc_add_s),
    .data  (adc_data),
    .sum   (acc_sum_s),
    .last  (acc_last_s)
  );

  // Next-state, settle counter and result update; a start always restarts settling.
  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    measured_d   = measured_q;
    meas_valid_d = 1'b0;
    if (start) begin
      state_d  = SETTLE;
      settle_d = SET_W'(SETTLE_CYCLES - 1);
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        SETTLE: begin
          if (settle_done_s) begin
            state_d = ACCUM;
          end else begin
            settle_d = settle_q - SET_W'(1);
          end
        end
        ACCUM:   state_d = ACCUM;
        default: state_d = IDLE;
      endcase
      if (acc_add_s && acc_last_s) begin
        measured_d   = WIDTH'(rounded_s >> LOG2_SAMPLES);
        meas_valid_d = 1'b1;
        state_d      = IDLE;
      end else begin
        meas_valid_d = 1'b0;
      end
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      settle_q     <= {SET_W{1'b0}};
      measured_q   <= {WIDTH{1'b0}};
      meas_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      measured_q   <= measured_d;
      meas_valid_q <= meas_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign meas_valid = meas_valid_q;
  assign busy       = busy_q;

endmodule
